// File: rtl/logo_pkg.sv
// Shared constants and the glyph rectangle ROM for the scrolling logo painter.
package logo_pkg;

  localparam logic [2:0] GLYPH_BLANK = 3'd0;
  localparam logic [2:0] GLYPH_H     = 3'd1;
  localparam logic [2:0] GLYPH_I     = 3'd2;
  localparam logic [2:0] GLYPH_T     = 3'd3;
  localparam logic [2:0] GLYPH_L     = 3'd4;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOME   = 2'b11
  } mode_t;

  localparam int CELL_W = 40;
  localparam int CELL_H = 40;
  localparam int RECTS  = 3;

  typedef struct packed {
    logic       valid;
    logic [5:0] dx;
    logic [5:0] dy;
    logic [5:0] w;
    logic [5:0] h;
  } rect_t;

  // Cell-relative rectangle idx of a glyph; unused slots come back with valid=0.
  function automatic rect_t glyph_rect(input logic [2:0] code, input logic [1:0] idx);
    rect_t r;
    r = '0;
    case (code)
      GLYPH_H: begin
        case (idx)
          2'd0:    r = '{1'b1, 6'd10, 6'd0,  6'd5,  6'd40};
          2'd1:    r = '{1'b1, 6'd30, 6'd0,  6'd5,  6'd40};
          2'd2:    r = '{1'b1, 6'd10, 6'd20, 6'd20, 6'd5};
          default: r = '0;
        endcase
      end
      GLYPH_I: begin
        if (idx == 2'd0) r = '{1'b1, 6'd20, 6'd0, 6'd5, 6'd40};
      end
      GLYPH_T: begin
        case (idx)
          2'd0:    r = '{1'b1, 6'd10, 6'd0, 6'd25, 6'd5};
          2'd1:    r = '{1'b1, 6'd20, 6'd0, 6'd5,  6'd40};
          default: r = '0;
        endcase
      end
      GLYPH_L: begin
        case (idx)
          2'd0:    r = '{1'b1, 6'd10, 6'd0,  6'd5,  6'd40};
          2'd1:    r = '{1'b1, 6'd10, 6'd35, 6'd20, 6'd5};
          default: r = '0;
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logo_glyph_hit.sv
// Combinational hit test of one pixel against the rectangles of one letter cell.
module logo_glyph_hit
  import logo_pkg::*;
#(
  parameter int XW = 11
) (
  input  logic [XW+1:0] origin_x,
  input  logic [XW+1:0] origin_y,
  input  logic [XW-1:0] x,
  input  logic [XW-1:0] y,
  input  logic [2:0]    code,
  output logic          hit
);

  localparam int AW = XW + 2;

  logic [RECTS-1:0] rect_hit;
  logic [AW-1:0]    px;
  logic [AW-1:0]    py;

  assign px = AW'(x);
  assign py = AW'(y);

  for (genvar gi = 0; gi < RECTS; gi++) begin : g_rect
    rect_t         r;
    logic [AW-1:0] x0;
    logic [AW-1:0] y0;
    logic [AW-1:0] x1;
    logic [AW-1:0] y1;

    assign r  = glyph_rect(code, 2'(gi));
    // Two spare bits keep right/bottom edges past the screen from wrapping.
    assign x0 = origin_x + AW'(r.dx);
    assign y0 = origin_y + AW'(r.dy);
    assign x1 = x0 + AW'(r.w);
    assign y1 = y0 + AW'(r.h);
    assign rect_hit[gi] = r.valid && (px >= x0) && (px < x1) && (py >= y0) && (py < y1);
  end

  assign hit = |rect_hit;

endmodule

// File: rtl/logo_scroller.sv
// Row of letter cells painted at a per-frame animated horizontal offset,
// two-stage pixel pipeline producing a registered hit flag.
module logo_scroller
  import logo_pkg::*;
#(
  parameter int XW       = 11,
  parameter int GLYPHS   = 4,
  parameter int BASE_X   = 500,
  parameter int BASE_Y   = 550,
  parameter int PITCH    = 40,
  parameter int STEP     = 1,
  parameter int SPAN_MAX = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  frame_tick,
  input  logic [1:0]            mode,
  input  logic [XW-1:0]         x,
  input  logic [XW-1:0]         y,
  input  logic [3*GLYPHS-1:0]   glyph_codes,
  output logic                  hit,
  output logic [XW-1:0]         delt,
  output logic                  dir
);

  localparam int AW = XW + 2;
  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [AW-1:0] SPAN_A = AW'(SPAN_MAX);
  localparam logic [XW-1:0] STEP_D = XW'(STEP);
  localparam logic [XW-1:0] SPAN_D = XW'(SPAN_MAX);
  localparam logic [AW-1:0] ORG_Y  = AW'(BASE_Y);

  logic [AW-1:0] delt_ext;
  logic [AW-1:0] delt_up;

  assign delt_ext = AW'(delt);
  assign delt_up  = delt_ext + STEP_A;

  // Offset state machine: mode is only looked at on an enabled frame tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      delt <= '0;
      dir  <= 1'b0;
    end else if (frame_tick && enable) begin
      case (mode_t'(mode))
        MODE_STATIC: begin
          delt <= delt;
          dir  <= dir;
        end
        MODE_WRAP: begin
          dir <= 1'b0;
          if (delt_up > SPAN_A) delt <= '0;
          else                  delt <= delt_up[XW-1:0];
        end
        MODE_BOUNCE: begin
          if (!dir) begin
            if (delt_up >= SPAN_A) begin
              delt <= SPAN_D;
              dir  <= 1'b1;
            end else begin
              delt <= delt_up[XW-1:0];
            end
          end else begin
            if (delt_ext <= STEP_A) begin
              delt <= '0;
              dir  <= 1'b0;
            end else begin
              delt <= delt - STEP_D;
            end
          end
        end
        MODE_HOME: begin
          delt <= '0;
          dir  <= 1'b0;
        end
        default: begin
          delt <= delt;
          dir  <= dir;
        end
      endcase
    end
  end

  // Stage 1: pixel, enable, codes and the cell origins for the current offset.
  logic [XW-1:0]       x_reg;
  logic [XW-1:0]       y_reg;
  logic                en_reg;
  logic [3*GLYPHS-1:0] codes_reg;
  logic [AW-1:0]       origin_reg [GLYPHS];
  logic [GLYPHS-1:0]   cell_hit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_reg     <= '0;
      y_reg     <= '0;
      en_reg    <= 1'b0;
      codes_reg <= '0;
    end else begin
      x_reg     <= x;
      y_reg     <= y;
      en_reg    <= enable;
      codes_reg <= glyph_codes;
    end
  end

  for (genvar gi = 0; gi < GLYPHS; gi++) begin : g_cell
    always_ff @(posedge clk) begin
      if (!rst) origin_reg[gi] <= '0;
      else      origin_reg[gi] <= AW'(BASE_X) + delt_ext + AW'(gi * PITCH);
    end

    logo_glyph_hit #(
      .XW(XW)
    ) u_glyph (
      .origin_x (origin_reg[gi]),
      .origin_y (ORG_Y),
      .x        (x_reg),
      .y        (y_reg),
      .code     (codes_reg[3*gi +: 3]),
      .hit      (cell_hit[gi])
    );
  end

  // Stage 2: registered OR of every cell, gated by the delayed enable.
  always_ff @(posedge clk) begin
    if (!rst) hit <= 1'b0;
    else      hit <= en_reg && (|cell_hit);
  end

endmodule

// File: tb/tb_logo_scroller.sv
// Self-checking bench: two scrollers (STEP=1 and STEP=7) against a behavioural model.
module tb_logo_scroller;

  localparam int XW     = 11;
  localparam int GLYPHS = 4;
  localparam int BASE_X = 500;
  localparam int BASE_Y = 550;
  localparam int PITCH  = 40;
  localparam int SPAN   = 200;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable = 1'b0;
  logic                frame_tick = 1'b0;
  logic [1:0]          mode = 2'b00;
  logic [XW-1:0]       x = '0;
  logic [XW-1:0]       y = '0;
  logic [3*GLYPHS-1:0] glyph_codes = {3'd4, 3'd3, 3'd2, 3'd1};

  logic          hit_v  [2];
  logic [XW-1:0] delt_v [2];
  logic          dir_v  [2];

  always #5 clk = ~clk;

  logo_scroller #(
    .XW(XW), .GLYPHS(GLYPHS), .BASE_X(BASE_X), .BASE_Y(BASE_Y),
    .PITCH(PITCH), .STEP(1), .SPAN_MAX(SPAN)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick), .mode(mode),
    .x(x), .y(y), .glyph_codes(glyph_codes),
    .hit(hit_v[0]), .delt(delt_v[0]), .dir(dir_v[0])
  );

  logo_scroller #(
    .XW(XW), .GLYPHS(GLYPHS), .BASE_X(BASE_X), .BASE_Y(BASE_Y),
    .PITCH(PITCH), .STEP(7), .SPAN_MAX(SPAN)
  ) dut7 (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick), .mode(mode),
    .x(x), .y(y), .glyph_codes(glyph_codes),
    .hit(hit_v[1]), .delt(delt_v[1]), .dir(dir_v[1])
  );

  int checks = 0;
  int failures = 0;

  // Reference model state per instance: offset, direction, expected pipeline contents.
  int step_of [2] = '{1, 7};
  int md   [2] = '{0, 0};
  int mdir [2] = '{0, 0};
  bit s1   [2] = '{1'b0, 1'b0};
  bit he   [2] = '{1'b0, 1'b0};

  function automatic bit in_rect(int rx, int ry, int dx, int dy, int w, int h);
    return (rx >= dx) && (rx < dx + w) && (ry >= dy) && (ry < dy + h);
  endfunction

  function automatic bit in_glyph(int code, int rx, int ry);
    case (code)
      1: return in_rect(rx, ry, 10, 0, 5, 40) || in_rect(rx, ry, 30, 0, 5, 40) ||
                in_rect(rx, ry, 10, 20, 20, 5);
      2: return in_rect(rx, ry, 20, 0, 5, 40);
      3: return in_rect(rx, ry, 10, 0, 25, 5) || in_rect(rx, ry, 20, 0, 5, 40);
      4: return in_rect(rx, ry, 10, 0, 5, 40) || in_rect(rx, ry, 10, 35, 20, 5);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_pixel(int px, int py, int d, logic [3*GLYPHS-1:0] codes);
    for (int k = 0; k < GLYPHS; k++) begin
      if (in_glyph(int'(codes[3*k +: 3]), px - (BASE_X + d + k * PITCH), py - BASE_Y))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_tick(int i);
    int s;
    s = step_of[i];
    case (mode)
      2'b01: begin
        mdir[i] = 0;
        md[i] = (md[i] + s > SPAN) ? 0 : md[i] + s;
      end
      2'b10: begin
        if (mdir[i] == 0) begin
          if (md[i] + s >= SPAN) begin md[i] = SPAN; mdir[i] = 1; end
          else md[i] = md[i] + s;
        end else begin
          if (md[i] <= s) begin md[i] = 0; mdir[i] = 0; end
          else md[i] = md[i] - s;
        end
      end
      2'b11: begin md[i] = 0; mdir[i] = 0; end
      default: ;
    endcase
  endfunction

  // One clock with the currently driven inputs; advances the model alongside.
  task automatic step();
    bit nxt [2];
    for (int i = 0; i < 2; i++)
      nxt[i] = enable && model_pixel(int'(x), int'(y), md[i], glyph_codes);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        md[i] = 0; mdir[i] = 0; s1[i] = 1'b0; he[i] = 1'b0;
      end else begin
        he[i] = s1[i];
        s1[i] = nxt[i];
        if (frame_tick && enable) model_tick(i);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b1; frame_tick = 1'b1; mode = 2'b01;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (delt_v[i] !== '0 || dir_v[i] !== 1'b0 || hit_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d: got delt=%0d dir=%0b hit=%0b expected 0 0 0",
                 i, delt_v[i], dir_v[i], hit_v[i]);
      end
    end
    rst = 1'b1; frame_tick = 1'b0; mode = 2'b00;
    x = 11'd512; y = 11'd560;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (hit_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_release dut%0d: got hit=%0b expected 0", i, hit_v[i]);
      end
    end
  endtask

  task automatic test_static();
    int px [4] = '{512, 520, 520, 515};
    int py [4] = '{560, 560, 572, 560};
    bit ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    mode = 2'b00; enable = 1'b1; frame_tick = 1'b0;
    for (int p = 0; p < 4; p++) begin
      x = XW'(px[p]); y = XW'(py[p]);
      step(); step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (hit_v[i] !== ex[p]) begin
          failures++;
          $display("FAIL static_pixel dut%0d (%0d,%0d): got hit=%0b expected %0b",
                   i, px[p], py[p], hit_v[i], ex[p]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    mode = 2'b11; frame_tick = 1'b1; step();
    mode = 2'b01; x = 11'd512; y = 11'd560;
    for (int t = 0; t < 200; t++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (hit_v[i] !== he[i] || delt_v[i] !== XW'(md[i])) begin
          failures++;
          $display("FAIL wrap_step dut%0d t=%0d: got hit=%0b delt=%0d expected hit=%0b delt=%0d",
                   i, t, hit_v[i], delt_v[i], he[i], md[i]);
        end
      end
    end
    checks++;
    if (delt_v[0] !== 11'd200 || dir_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_top: got delt=%0d dir=%0b expected 200 0", delt_v[0], dir_v[0]);
    end
    step();
    checks++;
    if (delt_v[0] !== 11'd0) begin
      failures++;
      $display("FAIL wrap_around: got delt=%0d expected 0", delt_v[0]);
    end
    frame_tick = 1'b0; step(); step();
    checks++;
    if (hit_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL wrap_rehit: got hit=%0b expected 1", hit_v[0]);
    end
  endtask

  task automatic test_bounce();
    mode = 2'b11; frame_tick = 1'b1; step();
    mode = 2'b10;
    for (int k = 1; k <= 28; k++) begin
      step();
      checks++;
      if (delt_v[1] !== XW'(7 * k) || dir_v[1] !== 1'b0) begin
        failures++;
        $display("FAIL bounce_up k=%0d: got delt=%0d dir=%0b expected %0d 0",
                 k, delt_v[1], dir_v[1], 7 * k);
      end
    end
    step();
    checks++;
    if (delt_v[1] !== 11'd200 || dir_v[1] !== 1'b1) begin
      failures++;
      $display("FAIL bounce_top: got delt=%0d dir=%0b expected 200 1", delt_v[1], dir_v[1]);
    end
    for (int k = 1; k <= 28; k++) begin
      step();
      checks++;
      if (delt_v[1] !== XW'(200 - 7 * k) || dir_v[1] !== 1'b1) begin
        failures++;
        $display("FAIL bounce_down k=%0d: got delt=%0d dir=%0b expected %0d 1",
                 k, delt_v[1], dir_v[1], 200 - 7 * k);
      end
    end
    step();
    checks++;
    if (delt_v[1] !== 11'd0 || dir_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL bounce_bottom: got delt=%0d dir=%0b expected 0 0", delt_v[1], dir_v[1]);
    end
    checks++;
    if (delt_v[0] !== XW'(md[0]) || dir_v[0] !== mdir[0][0]) begin
      failures++;
      $display("FAIL bounce_step1: got delt=%0d dir=%0b expected %0d %0d",
               delt_v[0], dir_v[0], md[0], mdir[0]);
    end
  endtask

  task automatic test_enable();
    mode = 2'b11; frame_tick = 1'b1; step();
    enable = 1'b0; mode = 2'b01; x = 11'd512; y = 11'd560;
    for (int t = 0; t < 10; t++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (delt_v[i] !== 11'd0 || (t >= 1 && hit_v[i] !== 1'b0)) begin
          failures++;
          $display("FAIL enable_off dut%0d t=%0d: got delt=%0d hit=%0b expected 0 0",
                   i, t, delt_v[i], hit_v[i]);
        end
      end
    end
    enable = 1'b1; frame_tick = 1'b0;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (hit_v[i] !== 1'b1) begin
        failures++;
        $display("FAIL enable_on dut%0d: got hit=%0b expected 1", i, hit_v[i]);
      end
    end
  endtask

  task automatic test_tick_pixel();
    mode = 2'b11; frame_tick = 1'b1; step();
    mode = 2'b01; x = 11'd514; y = 11'd560; frame_tick = 1'b1;
    step();
    x = 11'd515; frame_tick = 1'b0;
    step();
    checks++;
    if (hit_v[0] !== 1'b1 || hit_v[1] !== he[1]) begin
      failures++;
      $display("FAIL tick_pixel_old: got hit=%0b/%0b expected 1/%0b", hit_v[0], hit_v[1], he[1]);
    end
    x = 11'd0;
    step();
    checks++;
    if (hit_v[0] !== 1'b1 || hit_v[1] !== he[1]) begin
      failures++;
      $display("FAIL tick_pixel_new: got hit=%0b/%0b expected 1/%0b", hit_v[0], hit_v[1], he[1]);
    end
  endtask

  task automatic test_reset_mid_bounce();
    int guard;
    mode = 2'b11; frame_tick = 1'b1; step();
    mode = 2'b10; x = 11'd512; y = 11'd560;
    guard = 0;
    while (!(md[0] == 120 && mdir[0] == 1) && guard < 400) begin
      step();
      guard++;
    end
    checks++;
    if (delt_v[0] !== 11'd120 || dir_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL bounce_reach120: got delt=%0d dir=%0b expected 120 1", delt_v[0], dir_v[0]);
    end
    rst = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (delt_v[i] !== '0 || dir_v[i] !== 1'b0 || hit_v[i] !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset dut%0d: got delt=%0d dir=%0b hit=%0b expected 0 0 0",
                 i, delt_v[i], dir_v[i], hit_v[i]);
      end
    end
    rst = 1'b1; frame_tick = 1'b0;
    step();
    checks++;
    if (hit_v[0] !== 1'b0 || hit_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_hit: got hit=%0b/%0b expected 0/0", hit_v[0], hit_v[1]);
    end
    frame_tick = 1'b1;
    step();
    checks++;
    if (delt_v[0] !== 11'd1 || delt_v[1] !== 11'd7 || dir_v[0] !== 1'b0 || dir_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_tick: got delt=%0d/%0d dir=%0b/%0b expected 1/7 0/0",
               delt_v[0], delt_v[1], dir_v[0], dir_v[1]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) != 0);
      enable     = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      mode       = 2'($urandom_range(0, 3));
      x          = XW'(480 + $urandom_range(0, 420));
      y          = XW'(540 + $urandom_range(0, 60));
      if ($urandom_range(0, 49) == 0) glyph_codes = 12'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (hit_v[i] !== he[i] || delt_v[i] !== XW'(md[i]) || dir_v[i] !== mdir[i][0]) begin
          failures++;
          $display("FAIL random dut%0d n=%0d: got hit=%0b delt=%0d dir=%0b expected %0b %0d %0d",
                   i, n, hit_v[i], delt_v[i], dir_v[i], he[i], md[i], mdir[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_wrap();
    test_bounce();
    test_enable();
    test_tick_pixel();
    test_reset_mid_bounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
